// File: rtl/pattern_feeder.sv
// pattern_feeder: stores a chart of timestamped pattern events and releases them in order
// once the game counter is within LOOKAHEAD ticks of each event's timestamp.
module pattern_feeder #(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned LOOKAHEAD = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       load_valid,
   input  logic [17:0]                load_data,
   output logic                       load_ready,
   input  logic                       start,
   input  logic                       rewind,
   input  logic                       clear,
   input  logic [9:0]                 counter10h,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [17:0]                pattern_with_timestamp,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       done,
   output logic                       order_error
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {StLoad, StFetch, StWait, StPlayOut, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [9:0]      last_ts_q, last_ts_d;
   logic            order_error_q, order_error_d;
   logic            load_ready_q, load_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            done_q, done_d;
   logic [17:0]     data_q;
   logic            wr_en;
   logic            release_ok;

   logic [17:0]     mem [DEPTH];

   // 11-bit sum so a large counter plus lookahead cannot wrap past the timestamp
   assign release_ok = ({1'b0, counter10h} + 11'(LOOKAHEAD)) >= {1'b0, data_q[17:8]};

   // Next-state, chart bookkeeping and registered-output targets
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      last_ts_d     = last_ts_q;
      order_error_d = order_error_q;
      wr_en         = 1'b0;

      if (clear) begin
         count_d       = '0;
         rd_ptr_d      = '0;
         order_error_d = 1'b0;
         last_ts_d     = '0;
         state_d       = StLoad;
      end else if (rewind && (state_q != StLoad)) begin
         rd_ptr_d = '0;
         state_d  = (count_q == '0) ? StDone : StFetch;
      end else begin
         case (state_q)
            StLoad: begin
               if (load_valid && load_ready_q) begin
                  // last_ts starts at 0, so the first word always passes
                  if (load_data[17:8] >= last_ts_q) begin
                     wr_en     = 1'b1;
                     count_d   = count_q + CW'(1);
                     last_ts_d = load_data[17:8];
                  end else begin
                     order_error_d = 1'b1;
                  end
               end
               // A word accepted alongside start still counts toward the chart
               if (start) begin
                  rd_ptr_d = '0;
                  state_d  = (count_d == '0) ? StDone : StFetch;
               end
            end
            StFetch: state_d = StWait;
            StWait: begin
               if (release_ok) state_d = StPlayOut;
            end
            StPlayOut: begin
               if (out_ready) begin
                  rd_ptr_d = rd_ptr_q + CW'(1);
                  state_d  = (rd_ptr_d == count_q) ? StDone : StFetch;
               end
            end
            StDone: ;
            default: state_d = StLoad;
         endcase
      end

      load_ready_d = (state_d == StLoad) && (count_d < CW'(DEPTH));
      out_valid_d  = (state_d == StPlayOut);
      done_d       = (state_d == StDone);
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StLoad;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         last_ts_q     <= '0;
         order_error_q <= 1'b0;
         load_ready_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         done_q        <= 1'b0;
         data_q        <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         last_ts_q     <= last_ts_d;
         order_error_q <= order_error_d;
         load_ready_q  <= load_ready_d;
         out_valid_q   <= out_valid_d;
         done_q        <= done_d;
         // Synchronous read; the fetched word stays put through WAIT and PLAY_OUT
         if (state_q == StFetch) data_q <= mem[rd_ptr_q[AW-1:0]];
      end
   end

   // Chart storage; contents are not reset, count alone marks validity
   always_ff @(posedge clock) begin
      if (wr_en) mem[count_q[AW-1:0]] <= load_data;
   end

   assign load_ready             = load_ready_q;
   assign out_valid              = out_valid_q;
   assign pattern_with_timestamp = data_q;
   assign count                  = count_q;
   assign done                   = done_q;
   assign order_error            = order_error_q;

endmodule

// File: tb/tb_pattern_feeder.sv
// Randomized scoreboard bench for pattern_feeder with a queue-based chart model.
module tb_pattern_feeder;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned LA    = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          load_valid = 1'b0;
   logic [17:0]   load_data = '0;
   logic          load_ready;
   logic          start = 1'b0;
   logic          rewind = 1'b0;
   logic          clear = 1'b0;
   logic [9:0]    counter10h = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [17:0]   pwt;
   logic [CW-1:0] count;
   logic          done;
   logic          order_error;

   pattern_feeder #(.DEPTH(DEPTH), .LOOKAHEAD(LA)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .load_valid             (load_valid),
      .load_data              (load_data),
      .load_ready             (load_ready),
      .start                  (start),
      .rewind                 (rewind),
      .clear                  (clear),
      .counter10h             (counter10h),
      .out_valid              (out_valid),
      .out_ready              (out_ready),
      .pattern_with_timestamp (pwt),
      .count                  (count),
      .done                   (done),
      .order_error            (order_error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Chart model: accepted words in order, last accepted timestamp, error flag
   logic [17:0] mdl_chart[$];
   int          mdl_last = 0;
   bit          mdl_err = 1'b0;

   logic [17:0] exp_q[$];
   int          acc_ctr[$];
   int          last_acc = -100;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clock) cyc++;

   // Monitor: handshakes are visible at the negedge before the accepting edge
   always @(negedge clock) begin
      logic [17:0] e;
      if (!reset && out_valid && out_ready && !rewind && !clear) begin
         check("event_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("event_data", 32'(pwt), 32'(e));
            check("release_rule",
                  32'(({1'b0, counter10h} + 11'(LA)) >= {1'b0, e[17:8]}), 1);
            check("accept_gap", 32'((cyc - last_acc) >= 3), 1);
            acc_ctr.push_back(int'(counter10h));
            last_acc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_word(input int ts, input int pat);
      load_valid = 1'b1;
      load_data  = {10'(ts), 8'(pat)};
      if (mdl_chart.size() < DEPTH) begin
         if (ts >= mdl_last) begin
            mdl_chart.push_back({10'(ts), 8'(pat)});
            mdl_last = ts;
         end else begin
            mdl_err = 1'b1;
         end
      end
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mdl_chart.delete();
      mdl_last = 0;
      mdl_err  = 1'b0;
      exp_q.delete();
   endtask

   task automatic push_chart();
      foreach (mdl_chart[i]) exp_q.push_back(mdl_chart[i]);
   endtask

   task automatic do_start();
      push_chart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check("out_valid_wait", 32'(out_valid), 1);
   endtask

   task automatic play(input int cpt, input bit rand_ready);
      int n = 0;
      int k = 0;
      while (!done && n < 5000) begin
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick();
         n++;
         k++;
         if (k >= cpt) begin
            k = 0;
            if (counter10h != 10'd1023) counter10h = counter10h + 10'd1;
         end
      end
      out_ready = 1'b0;
      check("play_done", 32'(done), 1);
      check("sb_drained", 32'(exp_q.size()), 0);
   endtask

   initial begin
      logic [17:0] cap;
      int ts;

      // Reset values
      tick();
      check("rst_load_ready", 32'(load_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_pwt", 32'(pwt), 0);
      check("rst_count", 32'(count), 0);
      check("rst_done", 32'(done), 0);
      check("rst_order_error", 32'(order_error), 0);
      reset = 1'b0;
      check("load_ready_before_edge", 32'(load_ready), 0);
      tick();
      check("load_ready_after_edge", 32'(load_ready), 1);

      // Basic chart with equal timestamps, swept counter
      load_word(10, 8'h01);
      load_word(20, 8'h02);
      load_word(20, 8'h80);
      check("basic_count", 32'(count), 3);
      counter10h = 10'd0;
      acc_ctr.delete();
      do_start();
      play(10, 1'b0);
      check("basic_acc_n", 32'(acc_ctr.size()), 3);
      if (acc_ctr.size() == 3) begin
         check("basic_ctr0", 32'(acc_ctr[0]), 6);
         check("basic_ctr1", 32'(acc_ctr[1]), 16);
         check("basic_ctr2", 32'(acc_ctr[2]), 16);
      end
      check("basic_count_end", 32'(count), 3);

      // Out-of-order load and clear
      do_clear();
      load_word(50, 8'h11);
      load_word(40, 8'h22);
      check("order_count", 32'(count), 1);
      check("order_error_set", 32'(order_error), 1);
      do_clear();
      check("clear_order_error", 32'(order_error), 0);
      check("clear_count", 32'(count), 0);
      check("clear_load_ready", 32'(load_ready), 1);

      // Back-pressure: output must hold for 20 stalled cycles
      load_word(5, 8'hAA);
      load_word(7, 8'hBB);
      counter10h = 10'd100;
      out_ready  = 1'b0;
      do_start();
      wait_valid();
      cap = pwt;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("stall_valid", 32'(out_valid), 1);
         check("stall_data", 32'(pwt), 32'(cap));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("stall_valid_drop", 32'(out_valid), 0);
      play(1, 1'b0);

      // Fill to DEPTH, extra word ignored without error
      do_clear();
      for (int i = 0; i < int'(DEPTH); i++) load_word(i * 3, i + 1);
      check("full_load_ready", 32'(load_ready), 0);
      check("full_count", 32'(count), DEPTH);
      load_word(500, 8'h55);
      check("full_count_after", 32'(count), DEPTH);
      check("full_no_error", 32'(order_error), 0);
      counter10h = 10'd0;
      do_start();
      play(2, 1'b1);

      // Empty chart start
      do_clear();
      out_ready = 1'b1;
      do_start();
      check("empty_done", 32'(done), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("empty_no_valid", 32'(out_valid), 0);
      end
      out_ready = 1'b0;

      // Rewind with a pending event, then rewind from DONE
      do_clear();
      load_word(1, 8'hC1);
      load_word(2, 8'hC2);
      load_word(3, 8'hC3);
      counter10h = 10'd200;
      do_start();
      wait_valid();
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      check("rewind_valid_drop", 32'(out_valid), 0);
      exp_q.delete();
      push_chart();
      play(1, 1'b0);
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      check("rewind_done_clear", 32'(done), 0);
      push_chart();
      play(1, 1'b1);

      // Randomized charts
      for (int it = 0; it < 6; it++) begin
         int n;
         do_clear();
         n  = $urandom_range(1, DEPTH + 2);
         ts = 0;
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0 && ts > 0) begin
               load_word(ts - 1, $urandom_range(0, 255));
            end else begin
               ts = ts + $urandom_range(0, 5);
               load_word(ts, $urandom_range(0, 255));
            end
         end
         check("rand_count", 32'(count), 32'(mdl_chart.size()));
         check("rand_order_error", 32'(order_error), 32'(mdl_err));
         counter10h = 10'd0;
         do_start();
         play($urandom_range(1, 4), 1'b1);
      end

      // Asynchronous reset while an event is pending
      do_clear();
      load_word(3, 8'hE1);
      load_word(1, 8'hE2);
      counter10h = 10'd50;
      do_start();
      wait_valid();
      @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 0);
      check("arst_pwt", 32'(pwt), 0);
      check("arst_count", 32'(count), 0);
      check("arst_done", 32'(done), 0);
      check("arst_order_error", 32'(order_error), 0);
      check("arst_load_ready", 32'(load_ready), 0);
      exp_q.delete();
      mdl_chart.delete();
      mdl_last = 0;
      mdl_err  = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      check("arst_load_ready_back", 32'(load_ready), 1);
      check("arst_count_back", 32'(count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_feeder.md
# pattern_feeder

Chart sequencer that produces the 18-bit `{timestamp[9:0], pattern[7:0]}` event stream consumed by the pattern manager. Firmware or a test harness loads a chart of up to DEPTH events into internal storage. During play the block releases each event in order once the game counter comes within LOOKAHEAD ticks of the event's timestamp, using a valid/ready handshake. It sits between chart storage/host load logic and the pattern-manager input of the rhythm-game top level.

## Interface
- DEPTH, 64: chart capacity in events, power of two, 2..1024.
- LOOKAHEAD, 4: ticks of `counter10h` before an event's timestamp at which it is released, 0..1023.
- clock  in  1  system clock (10 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  chart word on `load_data` is valid.
- load_data  in  18  chart word: [17:8] timestamp, [7:0] pattern.
- load_ready  out  1  block accepts a chart word this cycle.
- start  in  1  single-cycle pulse that ends loading and begins play.
- rewind  in  1  single-cycle pulse that restarts play from event 0 and keeps the chart.
- clear  in  1  single-cycle pulse that empties the chart and returns to LOAD.
- counter10h  in  10  current game time from the game clock.
- out_valid  out  1  `pattern_with_timestamp` holds a released event.
- out_ready  in  1  consumer accepts the event.
- pattern_with_timestamp  out  18  released event, same packing as `load_data`.
- count  out  log2(DEPTH)+1  number of events loaded.
- done  out  1  all loaded events have been delivered.
- order_error  out  1  sticky flag: a load word was rejected because its timestamp was out of order.

## Operation
- States: LOAD, FETCH, WAIT, PLAY_OUT, DONE. Reset enters LOAD.
- **LOAD**
  - `load_ready` = 1 while count < DEPTH.
  - Each `load_valid & load_ready` cycle: if timestamp ≥ the previously accepted timestamp (always true for the first word), write the word at index count and increment count. Otherwise drop the word, leave count unchanged, and set `order_error`.
  - Equal timestamps are legal.
  - When count = DEPTH, `load_ready` = 0 and further words are ignored without error.
- **start in LOAD**
  - rd_ptr ← 0. If count = 0, go to DONE; otherwise go to FETCH.
  - A load handshake in the same cycle as start is still accepted and counted.
  - start outside LOAD is ignored.
- **FETCH**: issue a synchronous read at rd_ptr; the data is registered next cycle; go to WAIT.
- **WAIT**
  - Release condition: {1'b0, counter10h} + LOOKAHEAD ≥ {1'b0, timestamp}, using an 11-bit sum so there is no wrap.
  - When the condition is true, go to PLAY_OUT with `out_valid` = 1.
  - The condition is evaluated every cycle against the live `counter10h`.
- **PLAY_OUT**
  - `out_valid` = 1. `pattern_with_timestamp` stays stable until `out_ready`.
  - On `out_valid & out_ready`: rd_ptr++. If rd_ptr+1 = count, go to DONE; otherwise go to FETCH.
- **DONE**: `done` = 1, `out_valid` = 0.
- **rewind** (in FETCH, WAIT, PLAY_OUT, or DONE)
  - rd_ptr ← 0; go to FETCH (or DONE if count = 0).
  - Any pending unaccepted event is withdrawn: `out_valid` drops the next cycle.
  - rewind is ignored in LOAD.
- **clear** (any state)
  - count ← 0, rd_ptr ← 0, `order_error` ← 0, last-timestamp ← 0; go to LOAD.
  - Priority: clear > rewind > start > handshakes.
- Memory contents are not reset; validity is tracked only by count.

## Timing
- Reset values: `load_ready` 0, `out_valid` 0, `pattern_with_timestamp` 0, `count` 0, `done` 0, `order_error` 0.
- `load_ready` asserts on the first clock edge after reset deasserts.
- All outputs are registered. No combinational path from any input to any output.
- Load: an accepted word at edge E is reflected in `count` after E. `load_ready` falls in the cycle after the DEPTH-th accept.
- start at edge S: FETCH in S+1, WAIT in S+2. `out_valid` rises no earlier than edge S+3, and at the first edge after the release condition holds in WAIT.
- Accept at edge A: `out_valid` falls after A. The next event's `out_valid` rises no earlier than edge A+3. Throughput is at most one event per 3 cycles, far above game-tick rate.
- `counter10h` going backwards (game reset) does not rewind the block; only `rewind` does.
- Asynchronous reset mid-play returns immediately to the reset values and to LOAD with count 0.

## Test plan
- Load {ts=10,pat=0x01}, {ts=20,pat=0x02}, {ts=20,pat=0x80}; start; sweep `counter10h` 0→30 with `out_ready`=1, LOOKAHEAD=4 → events emitted when counter = 6, 16, 16 (second one ≥3 cycles later); `done`=1 after the third accept; count=3.
- Load ts 50 then ts 40 → second word dropped, count=1, `order_error`=1; clear → `order_error`=0, count=0, `load_ready`=1.
- Hold `out_ready`=0 for 20 cycles with an event pending → `out_valid` and `pattern_with_timestamp` stay constant; accept on cycle 21 → `out_valid` deasserts next cycle.
- Load DEPTH words, then present one more → `load_ready`=0, count=DEPTH, `order_error` stays 0.
- start with count=0 → `done`=1 within 1 cycle, `out_valid` never asserts. Mid-play rewind with an event pending → `out_valid` drops; event 0 is re-emitted.
- Assert reset while `out_valid`=1 → all outputs return to reset values immediately, without waiting for a clock edge.
